// File: rtl/rcc_ker_clk_seq_ctrl_if.sv
// Kernel-clock select request channel: requester drives reg_sel/sel_upd,
// the sequencer answers with busy/sel_done/sel_err.
interface rcc_ker_clk_seq_ctrl_if #(
  parameter int NCH   = 4,
  parameter int SEL_W = 2
);
  logic [NCH*SEL_W-1:0] reg_sel;
  logic [NCH-1:0]       sel_upd;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       sel_done;
  logic [NCH-1:0]       sel_err;

  modport master (
    output reg_sel, sel_upd,
    input  busy, sel_done, sel_err
  );

  modport slave (
    input  reg_sel, sel_upd,
    output busy, sel_done, sel_err
  );
endinterface

// File: rtl/rcc_ker_clk_seq_ctrl.sv
// Multi-channel kernel-clock gate merge and glitch-safe source switch
// sequencer (gate off, wait, switch mux, settle, re-enable).
module rcc_ker_clk_seq_ctrl #(
  parameter int NCH        = 4,
  parameter int NCORE      = 2,
  parameter int SEL_W      = 2,
  parameter int OFF_CYC    = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = 4,
  parameter int RST_SEL    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORE-1:0]       core_sleep,
  input  logic [NCORE-1:0]       core_deepsleep,
  input  logic                   testmode,
  input  logic [NCH*NCORE-1:0]   reg_en,
  input  logic [NCH*NCORE-1:0]   reg_lpen,
  rcc_ker_clk_seq_ctrl_if.slave  sif,
  output logic [NCH-1:0]         gate_en,
  output logic [NCH*SEL_W-1:0]   mux_sel
);

  typedef enum logic [1:0] {
    RUN,
    OFF_WAIT,
    SWITCH,
    SETTLE
  } st_e;

  localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] RSEL   = SEL_W'(RST_SEL);

  st_e              st_q   [NCH];
  st_e              st_d   [NCH];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [SEL_W-1:0] pend_q [NCH];
  logic [SEL_W-1:0] pend_d [NCH];
  logic [SEL_W-1:0] msel_q [NCH];
  logic [SEL_W-1:0] msel_d [NCH];
  logic [NCH-1:0]   gate_q, gate_d;
  logic [NCH-1:0]   busy_q, busy_d;
  logic [NCH-1:0]   done_q, done_d;
  logic [NCH-1:0]   err_q, err_d;
  logic [NCH-1:0]   req;
  logic [SEL_W-1:0] rsel;

  always_comb begin
    req = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int c = 0; c < NCORE; c++) begin
        req[i] = req[i]
               | (reg_en[i*NCORE+c]
               & (~core_sleep[c] | reg_lpen[i*NCORE+c])
               & ~core_deepsleep[c]);
      end
    end
  end

  always_comb begin
    rsel = '0;
    for (int i = 0; i < NCH; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      pend_d[i] = pend_q[i];
      msel_d[i] = msel_q[i];
      gate_d[i] = gate_q[i];
      busy_d[i] = busy_q[i];
      done_d[i] = 1'b0;
      err_d[i]  = 1'b0;
      rsel      = sif.reg_sel[i*SEL_W +: SEL_W];
      unique case (st_q[i])
        RUN: begin
          gate_d[i] = req[i];
          if (sif.sel_upd[i]) begin
            if (rsel != msel_q[i]) begin
              pend_d[i] = rsel;
              gate_d[i] = 1'b0;
              busy_d[i] = 1'b1;
              cnt_d[i]  = OFF_LD;
              st_d[i]   = OFF_WAIT;
            end else begin
              done_d[i] = 1'b1;
            end
          end
        end
        OFF_WAIT: begin
          gate_d[i] = 1'b0;
          if (sif.sel_upd[i]) pend_d[i] = rsel;
          if (cnt_q[i] == '0) st_d[i] = SWITCH;
          else cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        SWITCH: begin
          // pend is consumed on this edge, so a late request cannot land
          gate_d[i] = 1'b0;
          msel_d[i] = pend_q[i];
          cnt_d[i]  = SET_LD;
          st_d[i]   = SETTLE;
          err_d[i]  = sif.sel_upd[i];
        end
        SETTLE: begin
          gate_d[i] = 1'b0;
          if (cnt_q[i] == '0) begin
            // completion wins over a coincident request: done and err exclusive
            st_d[i]   = RUN;
            gate_d[i] = req[i];
            busy_d[i] = 1'b0;
            done_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
            err_d[i] = sif.sel_upd[i];
          end
        end
        default: st_d[i] = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]   <= RUN;
        cnt_q[i]  <= '0;
        pend_q[i] <= RSEL;
        msel_q[i] <= RSEL;
      end
      gate_q <= '0;
      busy_q <= '0;
      done_q <= '0;
      err_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      msel_q <= msel_d;
      gate_q <= gate_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ms
    assign mux_sel[g*SEL_W +: SEL_W] = msel_q[g];
  end

  assign gate_en      = testmode ? '1 : gate_q;
  assign sif.busy     = busy_q;
  assign sif.sel_done = done_q;
  assign sif.sel_err  = err_q;

endmodule

// File: tb/tb_rcc_ker_clk_seq_ctrl.sv
// Scoreboard bench: stimulus pushes model-predicted outputs per edge,
// a monitor pops and compares them after each rising edge.
module tb_rcc_ker_clk_seq_ctrl;
  localparam int NCH = 4;
  localparam int NC  = 2;
  localparam int SW  = 2;
  localparam int OFF = 4;
  localparam int SET = 8;
  localparam int RS  = 0;

  typedef struct packed {
    logic [NCH-1:0]    g;
    logic [NCH*SW-1:0] m;
    logic [NCH-1:0]    b;
    logic [NCH-1:0]    d;
    logic [NCH-1:0]    e;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     core_sleep, core_deepsleep;
  logic              testmode;
  logic [NCH*NC-1:0] reg_en, reg_lpen;
  logic [NCH-1:0]    gate_en;
  logic [NCH*SW-1:0] mux_sel;

  rcc_ker_clk_seq_ctrl_if #(.NCH(NCH), .SEL_W(SW)) sif ();

  rcc_ker_clk_seq_ctrl #(
    .NCH(NCH), .NCORE(NC), .SEL_W(SW), .OFF_CYC(OFF),
    .SETTLE_CYC(SET), .CNT_W(4), .RST_SEL(RS)
  ) dut (
    .clk(clk), .rst(rst),
    .core_sleep(core_sleep), .core_deepsleep(core_deepsleep),
    .testmode(testmode), .reg_en(reg_en), .reg_lpen(reg_lpen),
    .sif(sif), .gate_en(gate_en), .mux_sel(mux_sel)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // model: channel state is "start edge of the running sequence"
  logic [SW-1:0] m_msel [NCH];
  logic [SW-1:0] m_pend [NCH];
  bit            m_busy [NCH];
  int            m_s    [NCH];
  logic [NCH-1:0] m_gate, m_done, m_err;
  int            edge_no = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic req_of(input int ch);
    logic r = 1'b0;
    for (int c = 0; c < NC; c++)
      if (reg_en[ch*NC+c] && (!core_sleep[c] || reg_lpen[ch*NC+c])
          && !core_deepsleep[c]) r = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    exp_t x;
    int d;
    logic [SW-1:0] rs;
    for (int ch = 0; ch < NCH; ch++) begin
      rs = sif.reg_sel[ch*SW +: SW];
      m_done[ch] = 1'b0;
      m_err[ch]  = 1'b0;
      if (rst) begin
        m_msel[ch] = SW'(RS);
        m_pend[ch] = SW'(RS);
        m_busy[ch] = 1'b0;
        m_gate[ch] = 1'b0;
      end else if (!m_busy[ch]) begin
        m_gate[ch] = req_of(ch);
        if (sif.sel_upd[ch]) begin
          if (rs != m_msel[ch]) begin
            m_busy[ch] = 1'b1;
            m_s[ch]    = edge_no;
            m_pend[ch] = rs;
            m_gate[ch] = 1'b0;
          end else m_done[ch] = 1'b1;
        end
      end else begin
        d = edge_no - m_s[ch];
        if (d <= OFF) begin
          if (sif.sel_upd[ch]) m_pend[ch] = rs;
        end else if (d == OFF + 1) begin
          m_msel[ch] = m_pend[ch];
          m_err[ch]  = sif.sel_upd[ch];
        end else if (d <= OFF + SET) begin
          m_err[ch] = sif.sel_upd[ch];
        end else begin
          m_busy[ch] = 1'b0;
          m_gate[ch] = req_of(ch);
          m_done[ch] = 1'b1;
        end
      end
      x.m[ch*SW +: SW] = m_msel[ch];
      x.b[ch] = m_busy[ch];
    end
    x.g = testmode ? '1 : m_gate;
    x.d = m_done;
    x.e = m_err;
    q.push_back(x);
    edge_no++;
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    sif.sel_upd = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic upd(input int ch, input int sel);
    sif.reg_sel[ch*SW +: SW] = SW'(sel);
    sif.sel_upd[ch] = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("gate_en", 32'(gate_en), 32'(x.g));
        check("mux_sel", 32'(mux_sel), 32'(x.m));
        check("busy", 32'(sif.busy), 32'(x.b));
        check("sel_done", 32'(sif.sel_done), 32'(x.d));
        check("sel_err", 32'(sif.sel_err), 32'(x.e));
        check("done_err_excl", 32'(sif.sel_done & sif.sel_err), 32'(0));
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    testmode = 1'b0;
    core_sleep = '0;
    core_deepsleep = '0;
    reg_en = '0;
    reg_lpen = '0;
    sif.reg_sel = '0;
    sif.sel_upd = '0;
    ticks(2);
    rst = 1'b0;
    // enable merge on ch0
    reg_en[0] = 1'b1;
    core_sleep[0] = 1'b1;
    ticks(2);
    reg_lpen[0] = 1'b1;
    ticks(2);
    core_deepsleep[0] = 1'b1;
    ticks(2);
    reg_en[1] = 1'b1;
    ticks(2);
    core_deepsleep[0] = 1'b0;
    core_sleep[0] = 1'b0;
    for (int ch = 0; ch < NCH; ch++) reg_en[ch*NC+1] = 1'b1;
    ticks(2);
    // full switch on ch1, then same-select
    upd(1, 2);
    ticks(16);
    upd(1, 2);
    ticks(4);
    // overlap then settle-phase request on ch1
    upd(1, 1);
    ticks(2);
    upd(1, 3);
    ticks(6);
    upd(1, 0);
    ticks(10);
    // reset mid-sequence on ch3
    upd(3, 1);
    ticks(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(4);
    // testmode with staggered concurrent sequences
    testmode = 1'b1;
    upd(2, 3);
    tick();
    upd(0, 1);
    ticks(2);
    upd(3, 2);
    ticks(16);
    testmode = 1'b0;
    ticks(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) core_sleep = NC'($urandom);
      if ($urandom_range(15) == 0) core_deepsleep = NC'($urandom);
      if ($urandom_range(31) == 0) reg_en = (NCH*NC)'($urandom);
      if ($urandom_range(31) == 0) reg_lpen = (NCH*NC)'($urandom);
      if ($urandom_range(99) == 0) testmode = ~testmode;
      rst = ($urandom_range(499) == 0);
      sif.reg_sel = (NCH*SW)'($urandom);
      for (int ch = 0; ch < NCH; ch++)
        sif.sel_upd[ch] = ($urandom_range(11) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(2);
    @(posedge clk);
    #2;
    check("drain", 32'(q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
